// File: rtl/csr_file_m_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, op encodings,
// mstatus bit positions and interrupt cause codes.
package csr_file_m_pkg;

  typedef enum logic [1:0] {
    CsrOpNone  = 2'b00,
    CsrOpWrite = 2'b01,
    CsrOpSet   = 2'b10,
    CsrOpClear = 2'b11
  } csr_op_e;

  localparam logic [11:0] CsrMstatus   = 12'h300;
  localparam logic [11:0] CsrMie       = 12'h304;
  localparam logic [11:0] CsrMtvec     = 12'h305;
  localparam logic [11:0] CsrMscratch  = 12'h340;
  localparam logic [11:0] CsrMepc      = 12'h341;
  localparam logic [11:0] CsrMcause    = 12'h342;
  localparam logic [11:0] CsrMtval     = 12'h343;
  localparam logic [11:0] CsrMip       = 12'h344;
  localparam logic [11:0] CsrMcycle    = 12'hB00;
  localparam logic [11:0] CsrMcycleh   = 12'hB80;
  localparam logic [11:0] CsrMinstret  = 12'hB02;
  localparam logic [11:0] CsrMinstreth = 12'hB82;
  localparam logic [11:0] CsrMhartid   = 12'hF14;

  localparam int unsigned MstatusMie  = 3;
  localparam int unsigned MstatusMpie = 7;
  localparam logic [31:0] MstatusMpp  = 32'h0000_1800;

  localparam logic [4:0] IrqCodeTimer     = 5'd7;
  localparam logic [4:0] IrqCodeExt       = 5'd11;
  localparam logic [4:0] IrqCodeLocalBase = 5'd16;

  function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old_val,
                                            logic [31:0] wdata);
    logic [31:0] res;
    unique case (op)
      CsrOpWrite: res = wdata;
      CsrOpSet:   res = old_val | wdata;
      CsrOpClear: res = old_val & ~wdata;
      default:    res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_file_m_if.sv
// CSR access port: address/operand/op from the pipeline, read data and
// illegal flag back from the CSR file.
interface csr_file_m_if #(
  parameter int unsigned XLEN = 32
);
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [1:0]      csr_op;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;

  modport master (
    output csr_addr, csr_wdata, csr_op,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_addr, csr_wdata, csr_op,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/csr_file_m_csr_counter64.sv
// 64-bit free-running counter with independently writable halves; a write to
// either half suppresses that cycle's increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [63:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (we_lo) begin
      count_d[31:0] = wdata;
    end else if (we_hi) begin
      count_d[63:32] = wdata;
    end else if (inc) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: trap/mret state, interrupt pending/priority logic,
// and the mcycle/minstret counters.
module csr_file_m
  import csr_file_m_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_IRQ   = 4,
  parameter int unsigned HART_ID   = 0,
  parameter logic [31:0] RST_MTVEC = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  csr_file_m_if.slave        csr,
  input  logic               trap_valid,
  input  logic               trap_is_irq,
  input  logic [XLEN-1:0]    trap_cause,
  input  logic [XLEN-1:0]    trap_pc,
  input  logic [XLEN-1:0]    trap_tval,
  input  logic               mret_valid,
  input  logic               instr_retire,
  input  logic               timer_irq,
  input  logic               ext_irq,
  input  logic [NUM_IRQ-1:0] local_irq,
  output logic               irq_pending,
  output logic [XLEN-1:0]    irq_cause,
  output logic [XLEN-1:0]    trap_vector,
  output logic [XLEN-1:0]    mepc_o
);

  localparam logic [31:0] MieMask = 32'h0000_0888 | (((32'd1 << NUM_IRQ) - 32'd1) << 16);

  logic        status_mie_q, status_mie_d, status_mpie_q, status_mpie_d;
  logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [31:0] irq_raw, irq_s1_q, mip_q;
  logic [63:0] mcycle, minstret;
  logic [31:0] rdata, wval, irq_pend, cause_int;
  logic        illegal, read_only, csr_we, irq_any;
  logic [4:0]  irq_code;
  csr_op_e     op;

  assign op = csr_op_e'(csr.csr_op);

  // Two-flop synchroniser for every interrupt line; mip_q is the second stage.
  always_comb begin
    irq_raw                 = '0;
    irq_raw[7]              = timer_irq;
    irq_raw[11]             = ext_irq;
    irq_raw[16 +: NUM_IRQ]  = local_irq;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_s1_q <= '0;
      mip_q    <= '0;
    end else begin
      irq_s1_q <= irq_raw;
      mip_q    <= irq_s1_q;
    end
  end

  // Priority: ext > timer > lowest-index local line.
  always_comb begin
    irq_pend = mip_q & mie_q;
    irq_any  = |irq_pend;
    irq_code = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_pend[16 + i]) irq_code = IrqCodeLocalBase + 5'(i);
    end
    if (irq_pend[7])  irq_code = IrqCodeTimer;
    if (irq_pend[11]) irq_code = IrqCodeExt;
    cause_int = irq_any ? {1'b1, 26'b0, irq_code} : '0;
  end

  assign irq_pending = status_mie_q & irq_any;
  assign irq_cause   = cause_int;
  assign mepc_o      = mepc_q;

  always_comb begin
    trap_vector = {mtvec_q[31:2], 2'b00};
    if (mtvec_q[1:0] == 2'b01 && trap_is_irq) begin
      trap_vector = {mtvec_q[31:2], 2'b00} + {25'b0, irq_code, 2'b00};
    end
  end

  always_comb begin
    rdata     = '0;
    illegal   = 1'b0;
    read_only = 1'b0;
    case (csr.csr_addr)
      CsrMstatus:   rdata = MstatusMpp | (32'(status_mpie_q) << MstatusMpie)
                                       | (32'(status_mie_q) << MstatusMie);
      CsrMie:       rdata = mie_q;
      CsrMtvec:     rdata = mtvec_q;
      CsrMscratch:  rdata = mscratch_q;
      CsrMepc:      rdata = mepc_q;
      CsrMcause:    rdata = mcause_q;
      CsrMtval:     rdata = mtval_q;
      CsrMcycle:    rdata = mcycle[31:0];
      CsrMcycleh:   rdata = mcycle[63:32];
      CsrMinstret:  rdata = minstret[31:0];
      CsrMinstreth: rdata = minstret[63:32];
      CsrMip: begin
        rdata     = mip_q;
        read_only = 1'b1;
      end
      CsrMhartid: begin
        rdata     = HART_ID;
        read_only = 1'b1;
      end
      default:      illegal = 1'b1;
    endcase
    if (read_only && op != CsrOpNone) illegal = 1'b1;
  end

  assign csr.csr_rdata   = rdata;
  assign csr.csr_illegal = illegal;

  assign csr_we = (op != CsrOpNone) && !illegal && !trap_valid && !mret_valid;
  assign wval   = csr_apply(op, rdata, csr.csr_wdata);

  always_comb begin
    status_mie_d  = status_mie_q;
    status_mpie_d = status_mpie_q;
    mie_d         = mie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    if (trap_valid) begin
      mepc_d        = {trap_pc[31:2], 2'b00};
      mcause_d      = trap_is_irq ? cause_int : trap_cause;
      mtval_d       = trap_tval;
      status_mpie_d = status_mie_q;
      status_mie_d  = 1'b0;
    end else if (mret_valid) begin
      status_mie_d  = status_mpie_q;
      status_mpie_d = 1'b1;
    end else if (csr_we) begin
      case (csr.csr_addr)
        CsrMstatus: begin
          status_mie_d  = wval[MstatusMie];
          status_mpie_d = wval[MstatusMpie];
        end
        CsrMie:      mie_d = wval & MieMask;
        CsrMtvec: begin
          mtvec_d[31:2] = wval[31:2];
          // Reserved modes (1x) keep the current mode.
          if (!wval[1]) mtvec_d[1:0] = wval[1:0];
        end
        CsrMscratch: mscratch_d = wval;
        CsrMepc:     mepc_d     = {wval[31:2], 2'b00};
        CsrMcause:   mcause_d   = wval;
        CsrMtval:    mtval_d    = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_mie_q  <= 1'b0;
      status_mpie_q <= 1'b0;
      mie_q         <= '0;
      mtvec_q       <= RST_MTVEC;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
    end else begin
      status_mie_q  <= status_mie_d;
      status_mpie_q <= status_mpie_d;
      mie_q         <= mie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .we_lo (csr_we && csr.csr_addr == CsrMcycle),
    .we_hi (csr_we && csr.csr_addr == CsrMcycleh),
    .wdata (wval),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (instr_retire),
    .we_lo (csr_we && csr.csr_addr == CsrMinstret),
    .we_hi (csr_we && csr.csr_addr == CsrMinstreth),
    .wdata (wval),
    .count (minstret)
  );

endmodule

// File: tb/tb_csr_file_m.sv
// Self-checking bench for csr_file_m: expected read values are queued when a
// read is driven and compared once the DUT presents csr_rdata.
module tb_csr_file_m;
  import csr_file_m_pkg::*;

  localparam logic [31:0] RstMtvec = 32'h0000_0040;
  localparam int unsigned HartId   = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trap_valid = 1'b0, trap_is_irq = 1'b0, mret_valid = 1'b0;
  logic        instr_retire = 1'b0, timer_irq = 1'b0, ext_irq = 1'b0;
  logic [31:0] trap_cause = '0, trap_pc = '0, trap_tval = '0;
  logic [3:0]  local_irq = '0;
  logic        irq_pending;
  logic [31:0] irq_cause, trap_vector, mepc_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  csr_file_m_if #(.XLEN(32)) bus ();

  csr_file_m #(
    .XLEN      (32),
    .NUM_IRQ   (4),
    .HART_ID   (HartId),
    .RST_MTVEC (RstMtvec)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .csr          (bus),
    .trap_valid   (trap_valid),
    .trap_is_irq  (trap_is_irq),
    .trap_cause   (trap_cause),
    .trap_pc      (trap_pc),
    .trap_tval    (trap_tval),
    .mret_valid   (mret_valid),
    .instr_retire (instr_retire),
    .timer_irq    (timer_irq),
    .ext_irq      (ext_irq),
    .local_irq    (local_irq),
    .irq_pending  (irq_pending),
    .irq_cause    (irq_cause),
    .trap_vector  (trap_vector),
    .mepc_o       (mepc_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive a read at the negedge, compare a little later, then advance a cycle.
  task automatic csr_read(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    bus.csr_addr = addr;
    bus.csr_op   = CsrOpNone;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    check_val(tag_q.pop_front(), bus.csr_rdata, exp_q.pop_front());
    tick();
  endtask

  task automatic csr_write(input logic [11:0] addr, input csr_op_e op, input logic [31:0] data);
    bus.csr_addr  = addr;
    bus.csr_wdata = data;
    bus.csr_op    = op;
    tick();
    bus.csr_op    = CsrOpNone;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.csr_addr  = '0;
    bus.csr_wdata = '0;
    bus.csr_op    = CsrOpNone;
    repeat (2) @(negedge clk);
    #1;
    check_val("irq_pending_in_reset", {31'b0, irq_pending}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    csr_read(CsrMstatus, 32'h0000_1800, "mstatus_reset");
    csr_read(CsrMtvec, RstMtvec, "mtvec_reset");
    bus.csr_addr = CsrMhartid;
    #1;
    check_val("mhartid_legal", {31'b0, bus.csr_illegal}, 32'h0);
    csr_read(CsrMhartid, HartId, "mhartid");
    bus.csr_addr = 12'h7C0;
    #1;
    check_val("unmapped_illegal", {31'b0, bus.csr_illegal}, 32'h1);
    csr_read(12'h7C0, 32'h0, "unmapped_read");

    csr_write(CsrMie, CsrOpWrite, 32'hFFFF_FFFF);
    csr_read(CsrMie, 32'h000F_0888, "mie_mask");
    csr_write(CsrMie, CsrOpClear, 32'h8);
    csr_read(CsrMie, 32'h000F_0880, "mie_clear");

    csr_write(CsrMtvec, CsrOpWrite, 32'h0000_0101);
    csr_read(CsrMtvec, 32'h0000_0101, "mtvec_vectored");
    csr_write(CsrMtvec, CsrOpWrite, 32'h0000_0202);
    csr_read(CsrMtvec, 32'h0000_0201, "mtvec_mode_reserved");
    csr_write(CsrMtvec, CsrOpWrite, 32'h0000_0101);
    csr_write(CsrMstatus, CsrOpSet, 32'h8);
    csr_read(CsrMstatus, 32'h0000_1808, "mstatus_mie_set");

    // Timer interrupt must take two edges to appear.
    timer_irq = 1'b1;
    #1;
    check_val("pending_sync0", {31'b0, irq_pending}, 32'h0);
    tick();
    check_val("pending_sync1", {31'b0, irq_pending}, 32'h0);
    tick();
    check_val("pending_sync2", {31'b0, irq_pending}, 32'h1);
    check_val("cause_timer", irq_cause, 32'h8000_0007);

    // Interrupt trap with a competing mscratch write.
    trap_valid = 1'b1; trap_is_irq = 1'b1; trap_pc = 32'h1234; trap_tval = 32'hABC;
    bus.csr_addr = CsrMscratch; bus.csr_wdata = 32'hDEAD; bus.csr_op = CsrOpWrite;
    #1;
    check_val("trap_vector_irq", trap_vector, 32'h0000_011C);
    tick();
    trap_valid = 1'b0; trap_is_irq = 1'b0; bus.csr_op = CsrOpNone; timer_irq = 1'b0;
    check_val("pending_after_trap", {31'b0, irq_pending}, 32'h0);
    check_val("mepc_o", mepc_o, 32'h1234);
    csr_read(CsrMstatus, 32'h0000_1880, "mstatus_trap");
    csr_read(CsrMepc, 32'h1234, "mepc_trap");
    csr_read(CsrMcause, 32'h8000_0007, "mcause_irq");
    csr_read(CsrMtval, 32'hABC, "mtval_trap");
    csr_read(CsrMscratch, 32'h0, "mscratch_trap_drop");

    // mret outranks a CSR write in the same cycle.
    mret_valid = 1'b1;
    csr_write(CsrMscratch, CsrOpWrite, 32'hDEAD);
    mret_valid = 1'b0;
    csr_read(CsrMstatus, 32'h0000_1888, "mstatus_mret");
    csr_read(CsrMscratch, 32'h0, "mscratch_mret_drop");

    csr_write(CsrMscratch, CsrOpWrite, 32'hA5A5);
    csr_read(CsrMscratch, 32'hA5A5, "mscratch_write");

    // Exception trap: misaligned PC, non-vectored target.
    trap_valid = 1'b1; trap_cause = 32'd2; trap_pc = 32'h2003; trap_tval = 32'h77;
    bus.csr_addr = CsrMscratch; bus.csr_wdata = 32'hFFFF; bus.csr_op = CsrOpWrite;
    #1;
    check_val("trap_vector_exc", trap_vector, 32'h0000_0100);
    tick();
    trap_valid = 1'b0; bus.csr_op = CsrOpNone;
    csr_read(CsrMscratch, 32'hA5A5, "mscratch_exc_drop");
    csr_read(CsrMepc, 32'h2000, "mepc_aligned");
    csr_read(CsrMcause, 32'd2, "mcause_exc");
    csr_read(CsrMtval, 32'h77, "mtval_exc");
    csr_read(CsrMstatus, 32'h0000_1880, "mstatus_exc");
    mret_valid = 1'b1;
    tick();
    mret_valid = 1'b0;
    csr_read(CsrMstatus, 32'h0000_1888, "mstatus_mret2");

    // mcycle carry from low to high half.
    csr_write(CsrMcycleh, CsrOpWrite, 32'h0);
    csr_write(CsrMcycle, CsrOpWrite, 32'hFFFF_FFFF);
    csr_read(CsrMcycle, 32'hFFFF_FFFF, "mcycle_lo_written");
    csr_read(CsrMcycle, 32'h0, "mcycle_lo_wrap");
    csr_read(CsrMcycleh, 32'h1, "mcycle_hi_carry");

    // minstret: write wins over retire; retire still counts under a trap.
    instr_retire = 1'b1;
    csr_write(CsrMinstret, CsrOpWrite, 32'd5);
    trap_valid = 1'b1; trap_cause = 32'd3;
    tick();
    trap_valid = 1'b0; instr_retire = 1'b0;
    csr_read(CsrMinstret, 32'd6, "minstret_trap_retire");
    csr_read(CsrMinstreth, 32'd0, "minstreth");

    // ext beats local[0]; then local[0] alone, vectored offset.
    csr_write(CsrMstatus, CsrOpSet, 32'h8);
    ext_irq = 1'b1; local_irq = 4'b0001; trap_is_irq = 1'b1;
    tick();
    tick();
    check_val("pending_ext", {31'b0, irq_pending}, 32'h1);
    check_val("cause_ext", irq_cause, 32'h8000_000B);
    check_val("vector_ext", trap_vector, 32'h0000_012C);
    ext_irq = 1'b0;
    tick();
    tick();
    check_val("cause_local0", irq_cause, 32'h8000_0010);
    check_val("vector_local0", trap_vector, 32'h0000_0140);
    local_irq = '0; trap_is_irq = 1'b0;

    bus.csr_addr = CsrMip; bus.csr_op = CsrOpWrite;
    #1;
    check_val("mip_write_illegal", {31'b0, bus.csr_illegal}, 32'h1);
    bus.csr_op = CsrOpNone;
    #1;
    check_val("mip_read_legal", {31'b0, bus.csr_illegal}, 32'h0);
    bus.csr_addr = CsrMhartid; bus.csr_op = CsrOpSet;
    #1;
    check_val("mhartid_write_illegal", {31'b0, bus.csr_illegal}, 32'h1);
    bus.csr_op = CsrOpNone;
    tick();

    // Reset during a pending write aborts it.
    bus.csr_addr = CsrMscratch; bus.csr_wdata = 32'h55; bus.csr_op = CsrOpWrite;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.csr_op = CsrOpNone;
    rst_n = 1'b1;
    csr_read(CsrMscratch, 32'h0, "mscratch_reset_abort");
    csr_read(CsrMstatus, 32'h0000_1800, "mstatus_after_reset");
    csr_read(CsrMie, 32'h0, "mie_after_reset");
    csr_read(CsrMtvec, RstMtvec, "mtvec_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
